sram_march_bist: RTL and testbench

- Parametrised on-chip March-test engine for the OpenRAM test array.
- Drives the shared port-0 control/data bus (addr0, din0, web0, wmask0) plus one active-low chip select per macro.
- Applies March C- or a simple write/read sweep to one selected SRAM, captures dout after a configurable read latency, and compares it against the expected value.
- Reports pass/fail, a saturating error count, and the first failing address/data; sits beside the scan/LA control logic in the user wrapper.

---
 rtl/sram_bist_pkg.sv | 69 ++++++
 rtl/sram_bist_checker.sv | 82 ++++++++
 rtl/sram_march_bist.sv | 207 ++++++++++++++++++++
 tb/tb_sram_march_bist.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bist_pkg.sv
// Shared types for the SRAM March BIST engine: FSM states, March elements,
// op encoding and the per-element op table.
package sram_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef enum logic [2:0] {
        M0,
        M1,
        M2,
        M3,
        M4,
        M5
    } elem_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_kind_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // pol = 0 selects the background pattern, pol = 1 its complement
    typedef struct packed {
        op_kind_e kind;
        logic     pol;
    } op_t;

    // Ops per element, indexed by elem_e (listed M5 down to M0)
    localparam logic [5:0][1:0] ELEM_OPS = {2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

    function automatic dir_e elem_dir(elem_e e);
        return (e == M3 || e == M4 || e == M5) ? DIR_DOWN : DIR_UP;
    endfunction

    function automatic op_t elem_op(elem_e e, logic idx);
        op_t op;
        op.kind = OP_RD;
        op.pol  = 1'b0;
        case (e)
            M0: begin
                op.kind = OP_WR;
                op.pol  = 1'b0;
            end
            M1, M3: begin
                op.kind = idx ? OP_WR : OP_RD;
                op.pol  = idx;
            end
            M2, M4: begin
                op.kind = idx ? OP_WR : OP_RD;
                op.pol  = !idx;
            end
            default: begin
                op.kind = OP_RD;
                op.pol  = 1'b0;
            end
        endcase
        return op;
    endfunction

endpackage

// File: rtl/sram_bist_checker.sv
// Read-data checker: delays each issued read by READ_LAT cycles, compares the
// selected macro's dout slice and keeps the error count and first-fail record.
module sram_bist_checker #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int NUM_SRAMS = 16,
    parameter int SEL_W     = $clog2(NUM_SRAMS),
    parameter int READ_LAT  = 1,
    parameter int ERR_CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        i_clear,
    input  logic                        i_rd_valid,
    input  logic [ADDR_W-1:0]           i_rd_addr,
    input  logic [DATA_W-1:0]           i_rd_exp,
    input  logic [SEL_W-1:0]            i_sel,
    input  logic [NUM_SRAMS*DATA_W-1:0] i_dout_flat,
    output logic [ERR_CNT_W-1:0]        o_err_count,
    output logic [ADDR_W-1:0]           o_first_fail_addr,
    output logic [DATA_W-1:0]           o_first_fail_data
);

    logic              r_pv [READ_LAT];
    logic [ADDR_W-1:0] r_pa [READ_LAT];
    logic [DATA_W-1:0] r_pe [READ_LAT];

    logic [ERR_CNT_W-1:0] r_err_count;
    logic [ADDR_W-1:0]    r_ff_addr;
    logic [DATA_W-1:0]    r_ff_data;
    logic [DATA_W-1:0]    w_dout;
    logic                 w_mismatch;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < READ_LAT; i++) r_pv[i] <= 1'b0;
        end else begin
            r_pv[0] <= i_rd_valid;
            for (int i = 1; i < READ_LAT; i++) r_pv[i] <= r_pv[i-1];
        end
    end

    // NOTE: address/expected stages carry no reset; only the valid bits
    // qualify them, so resetting this storage would add cost for nothing.
    always_ff @(posedge clk) begin
        r_pa[0] <= i_rd_addr;
        r_pe[0] <= i_rd_exp;
        for (int i = 1; i < READ_LAT; i++) begin
            r_pa[i] <= r_pa[i-1];
            r_pe[i] <= r_pe[i-1];
        end
    end

    // An out-of-range select reads as zero, so the run still records data.
    always_comb begin
        w_dout = '0;
        for (int i = 0; i < NUM_SRAMS; i++) begin
            if (SEL_W'(i) == i_sel) w_dout = i_dout_flat[i*DATA_W +: DATA_W];
        end
    end

    assign w_mismatch = r_pv[READ_LAT-1] && (w_dout != r_pe[READ_LAT-1]);

    always_ff @(posedge clk) begin
        if (!rstn || i_clear) begin
            r_err_count <= '0;
            r_ff_addr   <= '0;
            r_ff_data   <= '0;
        end else if (w_mismatch) begin
            if (r_err_count != '1) r_err_count <= r_err_count + 1'b1;
            if (r_err_count == '0) begin
                r_ff_addr <= r_pa[READ_LAT-1];
                r_ff_data <= w_dout;
            end
        end
    end

    assign o_err_count       = r_err_count;
    assign o_first_fail_addr = r_ff_addr;
    assign o_first_fail_data = r_ff_data;

endmodule

// File: rtl/sram_march_bist.sv
// March C- / write-read sweep engine driving the shared OpenRAM port-0 bus;
// owns the run FSM, address sequencing and registered bus drive.
module sram_march_bist
    import sram_bist_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int WMASK_W   = 4,
    parameter int NUM_SRAMS = 16,
    parameter int SEL_W     = $clog2(NUM_SRAMS),
    parameter int READ_LAT  = 1,
    parameter int ERR_CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        start,
    input  logic                        mode,
    input  logic [SEL_W-1:0]            sram_sel,
    input  logic [ADDR_W-1:0]           addr_max,
    input  logic [DATA_W-1:0]           pattern,
    input  logic [NUM_SRAMS*DATA_W-1:0] dout_flat,
    output logic [NUM_SRAMS-1:0]        csb0,
    output logic                        web0,
    output logic [WMASK_W-1:0]          wmask0,
    output logic [ADDR_W-1:0]           addr0,
    output logic [DATA_W-1:0]           din0,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [ERR_CNT_W-1:0]        err_count,
    output logic [ADDR_W-1:0]           first_fail_addr,
    output logic [DATA_W-1:0]           first_fail_data
);

    localparam int DRAIN_W = $clog2(READ_LAT + 1);

    state_e              r_state, w_state_nxt;
    elem_e               r_elem, w_elem_nxt, w_elem_after;
    logic                r_opi, w_opi_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic                r_ops_done, w_ops_done_nxt;
    logic [DRAIN_W-1:0]  r_drain_cnt;

    logic                r_mode;
    logic [SEL_W-1:0]    r_sel;
    logic [ADDR_W-1:0]   r_addr_max;
    logic [DATA_W-1:0]   r_pattern;

    logic [NUM_SRAMS-1:0] r_csb0, w_csb0;
    logic                 r_web0;
    logic [WMASK_W-1:0]   r_wmask0;
    logic [ADDR_W-1:0]    r_addr0;
    logic [DATA_W-1:0]    r_din0;
    logic                 r_rd_valid;
    logic [DATA_W-1:0]    r_rd_exp;
    logic                 r_busy, r_done;

    op_t                  w_op;
    logic                 w_down, w_op_last, w_addr_end;
    logic                 w_issue, w_accept, w_sel_ok;
    logic [DATA_W-1:0]    w_data;
    logic [ERR_CNT_W-1:0] w_err_count;

    assign w_sel_ok = ({1'b0, r_sel} < (SEL_W+1)'(NUM_SRAMS));

    // NOTE: every comb output gets a default before the case so that no path
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        w_op         = elem_op(r_elem, r_opi);
        w_down       = !r_mode && (elem_dir(r_elem) == DIR_DOWN);
        w_op_last    = r_opi || (ELEM_OPS[r_elem] == 2'd1);
        w_addr_end   = w_down ? (r_addr == '0) : (r_addr == r_addr_max);
        w_elem_after = r_mode ? M5 : elem_e'(r_elem + 3'd1);
        w_data       = w_op.pol ? ~r_pattern : r_pattern;

        w_state_nxt    = r_state;
        w_elem_nxt     = r_elem;
        w_opi_nxt      = r_opi;
        w_addr_nxt     = r_addr;
        w_ops_done_nxt = r_ops_done;
        w_issue        = 1'b0;
        w_accept       = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_accept       = 1'b1;
                    w_state_nxt    = ST_RUN;
                    w_elem_nxt     = M0;
                    w_opi_nxt      = 1'b0;
                    w_addr_nxt     = '0;
                    w_ops_done_nxt = 1'b0;
                end
            end
            ST_RUN: begin
                if (r_ops_done) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_issue = 1'b1;
                    if (!w_op_last) begin
                        w_opi_nxt = 1'b1;
                    end else begin
                        w_opi_nxt = 1'b0;
                        if (!w_addr_end) begin
                            w_addr_nxt = w_down ? r_addr - 1'b1 : r_addr + 1'b1;
                        end else if (r_elem == M5) begin
                            w_ops_done_nxt = 1'b1;
                        end else begin
                            w_elem_nxt = w_elem_after;
                            w_addr_nxt = (!r_mode && elem_dir(w_elem_after) == DIR_DOWN)
                                         ? r_addr_max : '0;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (r_drain_cnt == DRAIN_W'(READ_LAT - 1)) w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_csb0 = '1;
        if (w_issue && w_sel_ok) w_csb0[r_sel] = 1'b0;
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_elem      <= M0;
            r_opi       <= 1'b0;
            r_addr      <= '0;
            r_ops_done  <= 1'b0;
            r_drain_cnt <= '0;
            r_mode      <= 1'b0;
            r_sel       <= '0;
            r_addr_max  <= '0;
            r_pattern   <= '0;
            r_csb0      <= '1;
            r_web0      <= 1'b1;
            r_wmask0    <= '0;
            r_addr0     <= '0;
            r_din0      <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_exp    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_elem      <= w_elem_nxt;
            r_opi       <= w_opi_nxt;
            r_addr      <= w_addr_nxt;
            r_ops_done  <= w_ops_done_nxt;
            r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + 1'b1 : '0;
            if (w_accept) begin
                r_mode     <= mode;
                r_sel      <= sram_sel;
                r_addr_max <= addr_max;
                r_pattern  <= pattern;
            end
            r_csb0     <= w_csb0;
            r_web0     <= !(w_issue && w_op.kind == OP_WR);
            r_wmask0   <= {WMASK_W{w_issue}};
            r_addr0    <= w_issue ? r_addr : '0;
            r_din0     <= (w_issue && w_op.kind == OP_WR) ? w_data : '0;
            r_rd_valid <= w_issue && (w_op.kind == OP_RD);
            r_rd_exp   <= w_data;
            r_busy     <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
            r_done     <= (w_state_nxt == ST_DONE);
        end
    end

    sram_bist_checker #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NUM_SRAMS (NUM_SRAMS),
        .SEL_W     (SEL_W),
        .READ_LAT  (READ_LAT),
        .ERR_CNT_W (ERR_CNT_W)
    ) u_checker (
        .clk               (clk),
        .rstn              (rstn),
        .i_clear           (w_accept),
        .i_rd_valid        (r_rd_valid),
        .i_rd_addr         (r_addr0),
        .i_rd_exp          (r_rd_exp),
        .i_sel             (r_sel),
        .i_dout_flat       (dout_flat),
        .o_err_count       (w_err_count),
        .o_first_fail_addr (first_fail_addr),
        .o_first_fail_data (first_fail_data)
    );

    assign csb0      = r_csb0;
    assign web0      = r_web0;
    assign wmask0    = r_wmask0;
    assign addr0     = r_addr0;
    assign din0      = r_din0;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err_count = w_err_count;
    assign pass      = r_done && (w_err_count == '0);

endmodule

// File: tb/tb_sram_march_bist.sv
// Directed bench: three BIST instances (default, READ_LAT=3, ERR_CNT_W=2)
// share one behavioural SRAM model with injectable faults.
module tb_sram_march_bist;

    logic         clk = 1'b0;
    logic         rstn;
    logic [2:0]   start_v;
    logic         mode;
    logic [3:0]   sram_sel;
    logic [9:0]   addr_max;
    logic [31:0]  pattern;
    logic [511:0] dout_flat;

    logic [15:0]  csb_o  [3];
    logic         web_o  [3];
    logic [3:0]   wm_o   [3];
    logic [9:0]   addr_o [3];
    logic [31:0]  din_o  [3];
    logic         busy_o [3];
    logic         done_o [3];
    logic         pass_o [3];
    logic [15:0]  err_o  [2];
    logic [1:0]   err_sat;
    logic [9:0]   ffa_o  [3];
    logic [31:0]  ffd_o  [3];

    int n_checks = 0;
    int n_fail   = 0;

    // Model control and observation
    int          act = 0;
    int          fault = 0;
    int          exp_sel = 0;
    logic        clr_cnt = 1'b0;
    int          n_wr = 0, n_rd = 0, n_bad = 0;
    logic [31:0] mem [1024];
    logic        p_v [3];
    logic [31:0] p_d [3];
    int          p_i [3];
    int          m_hit, m_nlow, m_lat;
    logic [31:0] m_rd;
    logic [15:0] b_csb;
    logic        b_web;
    logic [3:0]  b_wm;
    logic [9:0]  b_addr;
    logic [31:0] b_din;

    always #5 clk = ~clk;

    sram_march_bist u_dut0 (
        .clk(clk), .rstn(rstn), .start(start_v[0]), .mode(mode), .sram_sel(sram_sel),
        .addr_max(addr_max), .pattern(pattern), .dout_flat(dout_flat),
        .csb0(csb_o[0]), .web0(web_o[0]), .wmask0(wm_o[0]), .addr0(addr_o[0]), .din0(din_o[0]),
        .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .err_count(err_o[0]),
        .first_fail_addr(ffa_o[0]), .first_fail_data(ffd_o[0])
    );

    sram_march_bist #(.READ_LAT(3)) u_dut1 (
        .clk(clk), .rstn(rstn), .start(start_v[1]), .mode(mode), .sram_sel(sram_sel),
        .addr_max(addr_max), .pattern(pattern), .dout_flat(dout_flat),
        .csb0(csb_o[1]), .web0(web_o[1]), .wmask0(wm_o[1]), .addr0(addr_o[1]), .din0(din_o[1]),
        .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .err_count(err_o[1]),
        .first_fail_addr(ffa_o[1]), .first_fail_data(ffd_o[1])
    );

    sram_march_bist #(.ERR_CNT_W(2)) u_dut2 (
        .clk(clk), .rstn(rstn), .start(start_v[2]), .mode(mode), .sram_sel(sram_sel),
        .addr_max(addr_max), .pattern(pattern), .dout_flat(dout_flat),
        .csb0(csb_o[2]), .web0(web_o[2]), .wmask0(wm_o[2]), .addr0(addr_o[2]), .din0(din_o[2]),
        .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]), .err_count(err_sat),
        .first_fail_addr(ffa_o[2]), .first_fail_data(ffd_o[2])
    );

    always_comb begin
        b_csb  = csb_o[act];
        b_web  = web_o[act];
        b_wm   = wm_o[act];
        b_addr = addr_o[act];
        b_din  = din_o[act];
        m_lat  = (act == 1) ? 3 : 1;
    end

    // Behavioural SRAM: captures on the edge, dout valid m_lat cycles after the op.
    always @(posedge clk) begin
        m_hit  = -1;
        m_nlow = 0;
        for (int i = 0; i < 16; i++) begin
            if (!b_csb[i]) begin
                m_hit  = i;
                m_nlow = m_nlow + 1;
            end
        end
        if (clr_cnt) begin
            n_wr  = 0;
            n_rd  = 0;
            n_bad = 0;
        end else if (m_nlow != 0) begin
            if (m_nlow != 1 || m_hit != exp_sel || b_wm != 4'hF) n_bad = n_bad + 1;
            if (!b_web) n_wr = n_wr + 1;
            else        n_rd = n_rd + 1;
        end
        if (m_nlow != 0 && !b_web) mem[b_addr] <= b_din;
        m_rd = mem[b_addr];
        if (fault == 1 && b_addr == 10'd2) m_rd[0] = 1'b0;
        if (fault == 2) m_rd = '0;
        p_v[0] <= (m_nlow != 0) && b_web;
        p_d[0] <= m_rd;
        p_i[0] <= m_hit;
        for (int j = 1; j < 3; j++) begin
            p_v[j] <= p_v[j-1];
            p_d[j] <= p_d[j-1];
            p_i[j] <= p_i[j-1];
        end
    end

    always_comb begin
        dout_flat = {16{32'hDEAD_BEEF}};
        if (p_v[m_lat-1]) dout_flat[p_i[m_lat-1]*32 +: 32] = p_d[m_lat-1];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    // Start a run on instance k; returns the edge count from start to done (-1 on timeout).
    task automatic run(input int k, input logic m, input logic [3:0] s, input logic [9:0] am,
                       input logic [31:0] p, input int repulse, output int cyc);
        @(negedge clk);
        act      = k;
        exp_sel  = s;
        mode     = m;
        sram_sel = s;
        addr_max = am;
        pattern  = p;
        clr_cnt  = 1'b1;
        start_v[k] = 1'b1;
        @(posedge clk);
        #1;
        start_v[k] = 1'b0;
        clr_cnt    = 1'b0;
        check("busy_after_start", busy_o[k], 1'b1);
        check("done_cleared", done_o[k], 1'b0);
        cyc = -1;
        for (int n = 1; n <= 2000; n++) begin
            @(posedge clk);
            #1;
            start_v[k] = (n == repulse);
            if (done_o[k]) begin
                cyc = n;
                break;
            end
        end
        start_v[k] = 1'b0;
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        rstn     = 1'b0;
        start_v  = '0;
        mode     = 1'b0;
        sram_sel = '0;
        addr_max = '0;
        pattern  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_csb0", csb_o[0], 16'hFFFF);
        check("rst_web0", web_o[0], 1'b1);
        check("rst_wmask0", wm_o[0], 4'h0);
        check("rst_addr0", addr_o[0], 10'd0);
        check("rst_din0", din_o[0], 32'd0);
        check("rst_busy", busy_o[0], 1'b0);
        check("rst_done", done_o[0], 1'b0);
        check("rst_pass", pass_o[0], 1'b0);
        check("rst_err", err_o[0], 16'd0);
        check("rst_ffa", ffa_o[0], 10'd0);
        check("rst_ffd", ffd_o[0], 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // March C-, N=4, fault-free
        fault = 0;
        run(0, 1'b0, 4'd3, 10'd3, 32'h0, -1, cyc);
        check("t1_cycles", cyc, 42);
        check("t1_pass", pass_o[0], 1'b1);
        check("t1_err", err_o[0], 16'd0);
        check("t1_bad_bus", n_bad, 0);
        check("t1_writes", n_wr, 20);
        check("t1_reads", n_rd, 20);
        check("t1_busy_end", busy_o[0], 1'b0);
        check("t1_csb_idle", csb_o[0], 16'hFFFF);

        // Bit 0 of address 2 stuck-at-0
        fault = 1;
        run(0, 1'b0, 4'd3, 10'd3, 32'h0, -1, cyc);
        check("t2_cycles", cyc, 42);
        check("t2_err", err_o[0], 16'd2);
        check("t2_ffa", ffa_o[0], 10'd2);
        check("t2_ffd", ffd_o[0], 32'hFFFF_FFFE);
        check("t2_pass", pass_o[0], 1'b0);

        // Sweep mode, N=1, READ_LAT=3
        fault = 0;
        run(1, 1'b1, 4'd5, 10'd0, 32'hA5A5_A5A5, -1, cyc);
        check("t3_cycles", cyc, 6);
        check("t3_writes", n_wr, 1);
        check("t3_reads", n_rd, 1);
        check("t3_bad_bus", n_bad, 0);
        check("t3_pass", pass_o[1], 1'b1);
        check("t3_err", err_o[1], 16'd0);

        // Reset in the middle of a failing run
        fault = 2;
        act = 0;
        exp_sel = 3;
        @(negedge clk);
        mode       = 1'b0;
        sram_sel   = 4'd3;
        addr_max   = 10'd3;
        pattern    = 32'hFFFF_FFFF;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("t4_err_before_rst", err_o[0], 16'd2);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("t4_rst_csb0", csb_o[0], 16'hFFFF);
        check("t4_rst_web0", web_o[0], 1'b1);
        check("t4_rst_busy", busy_o[0], 1'b0);
        check("t4_rst_done", done_o[0], 1'b0);
        check("t4_rst_err", err_o[0], 16'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("t4_rst_hold_csb0", csb_o[0], 16'hFFFF);
        end
        @(negedge clk);
        rstn  = 1'b1;
        fault = 0;
        run(0, 1'b0, 4'd3, 10'd3, 32'h0, -1, cyc);
        check("t4_rerun_cycles", cyc, 42);
        check("t4_rerun_pass", pass_o[0], 1'b1);
        check("t4_rerun_err", err_o[0], 16'd0);

        // start re-pulsed mid-run is ignored
        run(0, 1'b0, 4'd3, 10'd3, 32'h0, 15, cyc);
        check("t5_cycles", cyc, 42);
        check("t5_pass", pass_o[0], 1'b1);
        check("t5_writes", n_wr, 20);
        check("t5_reads", n_rd, 20);

        // All bits stuck-at-0 with a 2-bit error counter
        fault = 2;
        run(2, 1'b0, 4'd3, 10'd3, 32'h0, -1, cyc);
        check("t6_cycles", cyc, 42);
        check("t6_err_sat", err_sat, 2'd3);
        check("t6_pass", pass_o[2], 1'b0);
        check("t6_ffa", ffa_o[2], 10'd0);
        fault = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
